if_pc_unit: RTL

Parametrised program-counter and fetch-enable unit for the instruction-fetch stage. It replaces the fixed 16-bit free-running PC with a configurable-width PC that supports:
- pipeline stall
- branch/jump redirect
- exception vectoring
- halt/resume

It drives the instruction ROM address and chip-enable, and exposes a fetch counter for debug and performance.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/if_pc_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: fetch-unit state encoding and default vectors.
`ifndef CPU_PKG_DEFINES
`define CPU_PKG_DEFINES
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`endif

package cpu_pkg;

  localparam int unsigned PC_AW_DEF     = 16;
  localparam int unsigned RESET_VEC_DEF = 32'h0000_0000;
  localparam int unsigned EXC_VEC_DEF   = 32'h0000_0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

endpackage : cpu_pkg

// File: rtl/if_pc_unit.sv
// Instruction-fetch program counter with stall, redirect, exception vectoring,
// halt/resume and a free-running fetch counter. All outputs come straight from flops.
module if_pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned   AW        = PC_AW_DEF,
  parameter int unsigned   INC       = 1,
  parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEF),
  parameter logic [AW-1:0] EXC_VEC   = AW'(EXC_VEC_DEF),
  parameter int unsigned   CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [AW-1:0]    br_target_i,
  input  logic             exc_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic             ce,
  output logic [AW-1:0]    pc,
  output logic [CNT_W-1:0] fetch_cnt
);

  pc_state_e        state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic             ce_q, ce_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

  // State register; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VEC;
      ce_q        <= `WriteDisable;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ce_q        <= ce_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Next-state / next-PC selection.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;

    // A fetch is consumed on every unstalled RUN edge, redirects included.
    if ((state_q == RUN) && !stall_i) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (exc_i) begin
          pc_d = EXC_VEC;
        end else if (br_taken_i) begin
          pc_d = br_target_i;
        end else if (halt_i) begin
          state_d = HALT;
        end else if (!stall_i) begin
          pc_d = pc_q + AW'(INC);
        end
      end
      HALT: begin
        if (exc_i) begin
          pc_d    = EXC_VEC;
          state_d = RUN;
        end else begin
          // Redirect while halted is captured so resume fetches from the target.
          if (br_taken_i) begin
            pc_d = br_target_i;
          end
          if (resume_i) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ce_d = (state_d == RUN) ? `WriteEnable : `WriteDisable;
  end

  assign ce        = ce_q;
  assign pc        = pc_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule : if_pc_unit
